// File: rtl/cdb_pkg.sv
// cdb_pkg: shared widths and entry type for the common data bus producer side
package cdb_pkg;
  localparam int CDB_DATA_W  = 16;
  localparam int CDB_TAG_W   = 5;
  localparam int CDB_NUM_SRC = 4;
  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_entry_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational round-robin selection of up to two requesters starting at rr_ptr
module rr_pick2 #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [PW-1:0] idx0,
  output logic          vld0,
  output logic [PW-1:0] idx1,
  output logic          vld1,
  output logic [N-1:0]  grant
);
  int j;
  always_comb begin
    idx0 = '0;
    idx1 = '0;
    vld0 = 1'b0;
    vld1 = 1'b0;
    grant = '0;
    j = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(rr_ptr) + k) % N;
      if (req[j] && !vld0) begin
        vld0 = 1'b1;
        idx0 = PW'(j);
      end else if (req[j] && !vld1) begin
        vld1 = 1'b1;
        idx1 = PW'(j);
      end
    end
    if (vld0) grant[idx0] = 1'b1;
    if (vld1) grant[idx1] = 1'b1;
  end
endmodule

// File: rtl/cdb_broadcast_arbiter.sv
// cdb_broadcast_arbiter: buffers one result per source and broadcasts up to two per cycle
module cdb_broadcast_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SRC = CDB_NUM_SRC,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int TAG_W   = CDB_TAG_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [DATA_W-1:0]         cdb_data_0,
  output logic [DATA_W-1:0]         cdb_data_1,
  output logic [TAG_W-1:0]          cdb_tag_0,
  output logic [TAG_W-1:0]          cdb_tag_1,
  output logic                      cdb_valid_0,
  output logic                      cdb_valid_1
);
  localparam int PW = $clog2(NUM_SRC);
  logic [NUM_SRC-1:0] hold_valid, grant;
  logic [DATA_W-1:0]  hold_data [NUM_SRC];
  logic [TAG_W-1:0]   hold_tag  [NUM_SRC];
  logic [PW-1:0]      rr_ptr, idx0, idx1, last, ptr_nxt;
  logic               vld0, vld1;
  rr_pick2 #(.N(NUM_SRC), .PW(PW)) u_pick (
    .req(hold_valid), .rr_ptr(rr_ptr),
    .idx0(idx0), .vld0(vld0), .idx1(idx1), .vld1(vld1), .grant(grant)
  );
  // a draining entry may be refilled on the same edge, giving one result per cycle per source
  assign src_ready = {NUM_SRC{!flush}} & (~hold_valid | grant);
  assign last = vld1 ? idx1 : idx0;
  assign ptr_nxt = (int'(last) == NUM_SRC - 1) ? '0 : last + PW'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid  <= '0;
      rr_ptr      <= '0;
      cdb_valid_0 <= 1'b0;
      cdb_valid_1 <= 1'b0;
      cdb_data_0  <= '0;
      cdb_data_1  <= '0;
      cdb_tag_0   <= '0;
      cdb_tag_1   <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        hold_data[i] <= '0;
        hold_tag[i]  <= '0;
      end
    end else if (flush) begin
      hold_valid  <= '0;
      rr_ptr      <= '0;
      cdb_valid_0 <= 1'b0;
      cdb_valid_1 <= 1'b0;
    end else begin
      cdb_valid_0 <= vld0;
      cdb_valid_1 <= vld1;
      if (vld0) begin
        cdb_data_0 <= hold_data[idx0];
        cdb_tag_0  <= hold_tag[idx0];
        rr_ptr     <= ptr_nxt;
      end
      if (vld1) begin
        cdb_data_1 <= hold_data[idx1];
        cdb_tag_1  <= hold_tag[idx1];
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] && src_ready[i]) begin
          hold_valid[i] <= 1'b1;
          hold_data[i]  <= src_data[i*DATA_W +: DATA_W];
          hold_tag[i]   <= src_tag[i*TAG_W +: TAG_W];
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// tb_cdb_broadcast_arbiter: scenario tasks plus randomized traffic against a per-cycle reference model
module tb_cdb_broadcast_arbiter;
  localparam int N = 4, DW = 16, TW = 5;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [N-1:0] src_valid = '0, src_ready;
  logic [N*DW-1:0] src_data = '0;
  logic [N*TW-1:0] src_tag = '0;
  logic [DW-1:0] cdb_data_0, cdb_data_1;
  logic [TW-1:0] cdb_tag_0, cdb_tag_1;
  logic cdb_valid_0, cdb_valid_1;
  int errors = 0, checks = 0;
  bit m_hv [N];
  logic [DW-1:0] m_hd [N];
  logic [TW-1:0] m_ht [N];
  int m_ptr, w0, w1;
  bit m_v0, m_v1;
  logic [DW-1:0] m_d0, m_d1;
  logic [TW-1:0] m_t0, m_t1;
  logic [N-1:0] exp_ready;

  cdb_broadcast_arbiter dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .src_valid(src_valid),
    .src_data(src_data), .src_tag(src_tag), .src_ready(src_ready),
    .cdb_data_0(cdb_data_0), .cdb_data_1(cdb_data_1),
    .cdb_tag_0(cdb_tag_0), .cdb_tag_1(cdb_tag_1),
    .cdb_valid_0(cdb_valid_0), .cdb_valid_1(cdb_valid_1)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_hv[i] = 0; m_hd[i] = '0; m_ht[i] = '0;
    end
    m_ptr = 0; m_v0 = 0; m_v1 = 0; m_d0 = '0; m_d1 = '0; m_t0 = '0; m_t1 = '0;
  endtask

  // apply inputs and work out which pending results the model will broadcast
  task automatic drive(input logic [N-1:0] v, input logic f,
                       input logic [N*DW-1:0] d, input logic [N*TW-1:0] t);
    src_valid = v; flush = f; src_data = d; src_tag = t;
    w0 = -1; w1 = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (m_hv[j]) begin
        if (w0 < 0) w0 = j;
        else if (w1 < 0) w1 = j;
      end
    end
    for (int i = 0; i < N; i++) exp_ready[i] = !f && (!m_hv[i] || i == w0 || i == w1);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    if (flush) begin
      for (int i = 0; i < N; i++) m_hv[i] = 0;
      m_v0 = 0; m_v1 = 0; m_ptr = 0;
    end else begin
      m_v0 = (w0 >= 0); m_v1 = (w1 >= 0);
      if (m_v0) begin m_d0 = m_hd[w0]; m_t0 = m_ht[w0]; end
      if (m_v1) begin m_d1 = m_hd[w1]; m_t1 = m_ht[w1]; end
      if (w1 >= 0) m_ptr = (w1 + 1) % N;
      else if (w0 >= 0) m_ptr = (w0 + 1) % N;
      for (int i = 0; i < N; i++) begin
        if (i == w0 || i == w1) m_hv[i] = 0;
        if (src_valid[i] && exp_ready[i]) begin
          m_hv[i] = 1; m_hd[i] = src_data[i*DW +: DW]; m_ht[i] = src_tag[i*TW +: TW];
        end
      end
    end
    #1;
  endtask

  function automatic logic [N*TW-1:0] tags4(input int a, b, c, e);
    return {TW'(e), TW'(c), TW'(b), TW'(a)};
  endfunction

  task automatic idle();
    drive('0, 1'b0, '0, '0);
    step();
  endtask

  task automatic do_flush();
    drive('0, 1'b1, '0, '0);
    step();
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++;
    if (src_ready !== 4'b1111 || cdb_valid_0 !== 1'b0 || cdb_valid_1 !== 1'b0 || cdb_tag_0 !== '0 || cdb_data_0 !== '0) begin
      errors++; $display("FAIL reset_state ready=%b v0=%b v1=%b t0=%0d d0=%h want 1111/0/0/0/0", src_ready, cdb_valid_0, cdb_valid_1, cdb_tag_0, cdb_data_0);
    end
    drive(4'b1111, 1'b0, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, tags4(5, 6, 7, 8));
    step();
    idle();
    checks++;
    if (!(cdb_valid_0 && cdb_valid_1 && cdb_tag_0 == 5'd5 && cdb_tag_1 == 5'd6)) begin
      errors++; $display("FAIL pre_reset_bcast v=%b%b tags=%0d,%0d want 11 5,6", cdb_valid_0, cdb_valid_1, cdb_tag_0, cdb_tag_1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cdb_valid_0 !== 1'b0 || cdb_valid_1 !== 1'b0 || cdb_tag_0 !== '0 || cdb_tag_1 !== '0) begin
      errors++; $display("FAIL async_reset v=%b%b tags=%0d,%0d want 00 0,0", cdb_valid_0, cdb_valid_1, cdb_tag_0, cdb_tag_1);
    end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++;
    if (src_ready !== 4'b1111) begin
      errors++; $display("FAIL ready_after_reset got %b want 1111", src_ready);
    end
    idle();
    checks++;
    if (cdb_valid_0 !== 1'b0 || cdb_valid_1 !== 1'b0) begin
      errors++; $display("FAIL no_bcast_after_reset v=%b%b want 00", cdb_valid_0, cdb_valid_1);
    end
  endtask

  task automatic test_single();
    drive(4'b0100, 1'b0, {16'h0, 16'h00AA, 16'h0, 16'h0}, tags4(0, 0, 7, 0));
    checks++;
    if (src_ready !== 4'b1111) begin
      errors++; $display("FAIL single_ready got %b want 1111", src_ready);
    end
    step();
    checks++;
    if (cdb_valid_0 !== 1'b0) begin
      errors++; $display("FAIL single_latency v0=%b want 0 one cycle after handshake", cdb_valid_0);
    end
    idle();
    checks++;
    if (cdb_valid_0 !== 1'b1 || cdb_tag_0 !== 5'd7 || cdb_data_0 !== 16'h00AA || cdb_valid_1 !== 1'b0) begin
      errors++; $display("FAIL single_bcast v0=%b t0=%0d d0=%h v1=%b want 1 7 00aa 0", cdb_valid_0, cdb_tag_0, cdb_data_0, cdb_valid_1);
    end
    checks++;
    if (dut.rr_ptr !== 2'd3) begin
      errors++; $display("FAIL single_rr_ptr got %0d want 3", dut.rr_ptr);
    end
  endtask

  task automatic test_four();
    do_flush();
    drive(4'b1111, 1'b0, {16'hD004, 16'hC003, 16'hB002, 16'hA001}, tags4(1, 2, 3, 4));
    step();
    drive('0, 1'b0, '0, '0);
    checks++;
    if (src_ready !== 4'b0011) begin
      errors++; $display("FAIL four_ready_wait got %b want 0011", src_ready);
    end
    step();
    checks++;
    if (!(cdb_valid_0 && cdb_valid_1 && cdb_tag_0 == 5'd1 && cdb_tag_1 == 5'd2 && cdb_data_0 == 16'hA001 && cdb_data_1 == 16'hB002)) begin
      errors++; $display("FAIL four_first v=%b%b tags=%0d,%0d want 11 1,2", cdb_valid_0, cdb_valid_1, cdb_tag_0, cdb_tag_1);
    end
    drive('0, 1'b0, '0, '0);
    checks++;
    if (src_ready !== 4'b1111) begin
      errors++; $display("FAIL four_ready_granted got %b want 1111", src_ready);
    end
    step();
    checks++;
    if (!(cdb_valid_0 && cdb_valid_1 && cdb_tag_0 == 5'd3 && cdb_tag_1 == 5'd4 && cdb_data_1 == 16'hD004)) begin
      errors++; $display("FAIL four_second v=%b%b tags=%0d,%0d want 11 3,4", cdb_valid_0, cdb_valid_1, cdb_tag_0, cdb_tag_1);
    end
    idle();
    checks++;
    if (cdb_valid_0 !== 1'b0 || cdb_valid_1 !== 1'b0) begin
      errors++; $display("FAIL four_drained v=%b%b want 00", cdb_valid_0, cdb_valid_1);
    end
  endtask

  task automatic test_fairness();
    int seen2, seen3;
    seen2 = -1; seen3 = -1;
    do_flush();
    drive(4'b1111, 1'b0, {16'h0321, 16'h0320, 16'h0011, 16'h0010}, tags4(10, 11, 20, 21));
    step();
    for (int c = 0; c < 4; c++) begin
      drive(4'b0011, 1'b0, {32'h0, 16'(100 + c), 16'(200 + c)}, tags4(12 + 2 * c, 13 + 2 * c, 0, 0));
      step();
      if (cdb_valid_0 && cdb_tag_0 == 5'd20 || cdb_valid_1 && cdb_tag_1 == 5'd20) seen2 = c;
      if (cdb_valid_0 && cdb_tag_0 == 5'd21 || cdb_valid_1 && cdb_tag_1 == 5'd21) seen3 = c;
      checks++;
      if ({cdb_valid_0, cdb_valid_1, cdb_tag_0, cdb_tag_1, cdb_data_0, cdb_data_1} !== {m_v0, m_v1, m_t0, m_t1, m_d0, m_d1}) begin
        errors++; $display("FAIL fair_model c=%0d got v=%b%b t=%0d,%0d want v=%b%b t=%0d,%0d", c, cdb_valid_0, cdb_valid_1, cdb_tag_0, cdb_tag_1, m_v0, m_v1, m_t0, m_t1);
      end
    end
    checks++;
    if (seen2 < 0 || seen2 > 1 || seen3 < 0 || seen3 > 1) begin
      errors++; $display("FAIL fairness src2 at %0d src3 at %0d want both in 0..1", seen2, seen3);
    end
  endtask

  task automatic test_streaming();
    do_flush();
    for (int c = 0; c < 10; c++) begin
      drive(4'b0001, 1'b0, {48'h0, 16'(c * 3 + 1)}, tags4(c, 0, 0, 0));
      checks++;
      if (src_ready[0] !== 1'b1) begin
        errors++; $display("FAIL stream_ready c=%0d got %b want 1", c, src_ready[0]);
      end
      step();
      if (c >= 1) begin
        checks++;
        if (cdb_valid_0 !== 1'b1 || cdb_tag_0 !== TW'(c - 1) || cdb_data_0 !== 16'((c - 1) * 3 + 1) || cdb_valid_1 !== 1'b0) begin
          errors++; $display("FAIL stream_bcast c=%0d got v=%b%b t=%0d d=%h want 10 t=%0d", c, cdb_valid_0, cdb_valid_1, cdb_tag_0, cdb_data_0, c - 1);
        end
      end
    end
    idle();
    idle();
  endtask

  task automatic test_flush();
    do_flush();
    drive(4'b0111, 1'b0, {16'h0, 16'h0B0B, 16'h0A0A, 16'h0909}, tags4(9, 10, 11, 0));
    step();
    drive(4'b1111, 1'b1, {4{16'hFFFF}}, tags4(30, 30, 30, 30));
    checks++;
    if (src_ready !== 4'b0000) begin
      errors++; $display("FAIL flush_ready got %b want 0000", src_ready);
    end
    step();
    checks++;
    if (cdb_valid_0 !== 1'b0 || cdb_valid_1 !== 1'b0) begin
      errors++; $display("FAIL flush_bcast v=%b%b want 00", cdb_valid_0, cdb_valid_1);
    end
    for (int c = 0; c < 3; c++) begin
      idle();
      checks++;
      if (cdb_valid_0 !== 1'b0 || cdb_valid_1 !== 1'b0) begin
        errors++; $display("FAIL flush_stale c=%0d v=%b%b t=%0d,%0d want 00", c, cdb_valid_0, cdb_valid_1, cdb_tag_0, cdb_tag_1);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(N'($urandom), $urandom_range(0, 15) == 0, {$urandom, $urandom}, N*TW'($urandom));
      checks++;
      if (src_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready c=%0d got %b want %b", c, src_ready, exp_ready);
      end
      step();
      checks++;
      if ({cdb_valid_0, cdb_valid_1, cdb_tag_0, cdb_tag_1, cdb_data_0, cdb_data_1} !== {m_v0, m_v1, m_t0, m_t1, m_d0, m_d1}) begin
        errors++; $display("FAIL rand_bcast c=%0d got v=%b%b t=%0d,%0d d=%h,%h want v=%b%b t=%0d,%0d d=%h,%h", c, cdb_valid_0, cdb_valid_1, cdb_tag_0, cdb_tag_1, cdb_data_0, cdb_data_1, m_v0, m_v1, m_t0, m_t1, m_d0, m_d1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_four();
    test_fairness();
    test_streaming();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
